// File: rtl/cpu_seq_if.sv
// Sequencer-to-datapath bus: imem, control, alu on one side,
// regfile and data-memory write enables on the other.
interface cpu_seq_if;
   logic [15:0] pc;
   logic [15:0] instruction;
   logic [15:0] ir;
   logic        jump;
   logic        branch;
   logic        regwrite;
   logic        memwrite;
   logic        isZero;
   logic        reg_we;
   logic        mem_we;

   modport master (
      input  instruction, jump, branch,
      input  regwrite, memwrite, isZero,
      output pc, ir, reg_we, mem_we
   );

   modport slave (
      output instruction, jump, branch,
      output regwrite, memwrite, isZero,
      input  pc, ir, reg_we, mem_we
   );
endinterface

// File: rtl/cpu_seq.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/WB per instruction.
// Ports: clk, rst (sync, high), run, bus (datapath), busy,
// halted, instr_count (saturating retired count).
module cpu_seq #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   cpu_seq_if.master   bus,
   output logic        busy,
   output logic        halted,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, WB, HALT
   } state_t;

   state_t      state, state_n;
   logic [15:0] pc_q, pc_n;
   logic [15:0] ir_q, ir_n;
   logic [15:0] cnt_q, cnt_n;
   // {jump, branch, regwrite, memwrite} latched in DECODE
   logic [3:0]  ctl_q, ctl_n;
   logic        z_q, z_n;
   logic [15:0] off;
   logic [15:0] pc_seq;

   assign off    = {{12{ir_q[3]}}, ir_q[3:0]};
   assign pc_seq = pc_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         cnt_q <= '0;
         ctl_q <= '0;
         z_q   <= 1'b0;
      end else begin
         state <= state_n;
         pc_q  <= pc_n;
         ir_q  <= ir_n;
         cnt_q <= cnt_n;
         ctl_q <= ctl_n;
         z_q   <= z_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc_q;
      ir_n    = ir_q;
      cnt_n   = cnt_q;
      ctl_n   = ctl_q;
      z_n     = z_q;
      unique case (state)
         IDLE: begin
            if (run) state_n = FETCH;
         end
         FETCH: begin
            ir_n    = bus.instruction;
            state_n = DECODE;
         end
         DECODE: begin
            if (ir_q == HALT_WORD) begin
               state_n = HALT;
            end else begin
               ctl_n   = {bus.jump, bus.branch,
                          bus.regwrite, bus.memwrite};
               state_n = EXEC;
            end
         end
         EXEC: begin
            z_n     = bus.isZero;
            state_n = WB;
         end
         WB: begin
            // jump wins over a taken branch
            if (ctl_q[3])
               pc_n = {3'b000, ir_q[12:0]};
            else if (ctl_q[2] && z_q)
               pc_n = pc_seq + off;
            else
               pc_n = pc_seq;
            if (cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
            state_n = run ? FETCH : IDLE;
         end
         HALT: begin
            state_n = HALT;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.pc     = pc_q;
   assign bus.ir     = ir_q;
   assign bus.reg_we = (state == WB) && ctl_q[1];
   assign bus.mem_we = (state == WB) && ctl_q[0];

   assign busy        = (state == FETCH) || (state == DECODE) ||
                        (state == EXEC)  || (state == WB);
   assign halted      = (state == HALT);
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: cycle model plus directed programs.
// Test opcode map in ir[15:13]: 1 j, 2 b, 3 rw, 4 mw, 5 rw+mw, 6 j+b.
module tb_cpu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        busy;
   logic        halted;
   logic [15:0] instr_count;

   logic [15:0] mem [0:65535];
   logic        zflag;
   logic [7:0]  noise;
   logic [2:0]  gate;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   logic prev_we = 1'b0;

   cpu_seq_if bus ();

   cpu_seq #(
      .RESET_PC(16'h0000),
      .HALT_WORD(16'hFFFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .bus(bus.master),
      .busy(busy),
      .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] dec(input logic [15:0] i);
      case (i[15:13])
         3'd1:    return 4'b1000;
         3'd2:    return 4'b0100;
         3'd3:    return 4'b0010;
         3'd4:    return 4'b0001;
         3'd5:    return 4'b0011;
         3'd6:    return 4'b1100;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [15:0] npc(
      input logic [15:0] p,
      input logic [15:0] i,
      input logic [3:0]  c,
      input logic        zz
   );
      int off;
      int t;
      if (c[3]) return {3'b000, i[12:0]};
      off = i[3] ? int'(i[3:0]) - 16 : int'(i[3:0]);
      t = (c[2] && zz) ? int'(p) + 1 + off : int'(p) + 1;
      return 16'(t & 32'h0000FFFF);
   endfunction

   // imem / control / alu stand-ins; inputs outside their
   // sampling phase carry random junk that must be ignored
   assign bus.instruction = mem[bus.pc];
   assign {bus.jump, bus.branch, bus.regwrite, bus.memwrite} =
      dec(bus.ir) ^ ((gate != 3'd2) ? noise[3:0] : 4'b0000);
   assign bus.isZero = (gate == 3'd3) ? zflag : noise[4];

   // model: phase 0 idle, 1..4 instruction cycles, 5 halted
   logic [2:0]  m_ph;
   logic [15:0] m_pc, m_ir, m_cnt;
   logic [3:0]  m_c;
   logic        m_z;

   always @(posedge clk) begin
      if (rst) begin
         m_ph  <= 3'd0;
         m_pc  <= 16'h0000;
         m_ir  <= 16'h0000;
         m_cnt <= 16'h0000;
         m_c   <= 4'b0000;
         m_z   <= 1'b0;
      end else begin
         case (m_ph)
            3'd0: if (run) m_ph <= 3'd1;
            3'd1: begin
               m_ir <= mem[m_pc];
               m_ph <= 3'd2;
            end
            3'd2: begin
               if (m_ir == 16'hFFFF) m_ph <= 3'd5;
               else begin
                  m_c  <= dec(m_ir);
                  m_ph <= 3'd3;
               end
            end
            3'd3: begin
               m_z  <= zflag;
               m_ph <= 3'd4;
            end
            3'd4: begin
               m_pc  <= npc(m_pc, m_ir, m_c, m_z);
               m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
               m_ph  <= run ? 3'd1 : 3'd0;
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic b;
      b = (m_ph >= 3'd1) && (m_ph <= 3'd4);
      chk("pc", bus.pc, m_pc);
      chk("ir", bus.ir, m_ir);
      chk("instr_count", instr_count, m_cnt);
      chk("busy", 16'(busy), 16'(b));
      chk("halted", 16'(halted), 16'(m_ph == 3'd5));
      chk("reg_we", 16'(bus.reg_we), 16'(m_ph == 3'd4 && m_c[1]));
      chk("mem_we", 16'(bus.mem_we), 16'(m_ph == 3'd4 && m_c[0]));
      chk("we_twice", 16'(prev_we && bus.reg_we), 16'd0);
      prev_we = bus.reg_we;
      if (bus.reg_we === 1'b1) pulses++;
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         noise = 8'($urandom);
         gate  = m_ph;
      end
   endtask

   task automatic clr();
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
   endtask

   task automatic do_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulses = 0;
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b1;
      zflag = 1'b0;
      noise = 8'h00;
      gate = 3'd0;
      clr();

      // reset held two cycles with run high
      tick(2);
      chk("rst_pc", bus.pc, 16'h0000);
      chk("rst_ir", bus.ir, 16'h0000);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_cnt", instr_count, 16'h0000);

      // straight-line: three register writes then halt
      mem[0] = 16'h6000;
      mem[1] = 16'h6000;
      mem[2] = 16'h6000;
      mem[3] = 16'hFFFF;
      rst = 1'b0;
      pulses = 0;
      tick();
      chk("start_busy", 16'(busy), 16'd1);
      tick(12);
      chk("sl_pc", bus.pc, 16'h0003);
      chk("sl_cnt", instr_count, 16'h0003);
      chk("sl_pulses", 16'(pulses), 16'd3);
      tick(2);
      chk("sl_halted", 16'(halted), 16'd1);

      // jump+branch at pc0 (jump wins), plain jump at pc1
      clr();
      mem[0] = 16'hC001;
      mem[1] = 16'h2010;
      mem[16] = 16'hFFFF;
      zflag = 1'b1;
      do_rst();
      tick(5);
      chk("jprio_pc", bus.pc, 16'h0001);
      tick(4);
      chk("jmp_pc", bus.pc, 16'h0010);
      chk("jmp_pulses", 16'(pulses), 16'd0);

      // branch at pc5, offset -2, taken and not taken
      clr();
      mem[0] = 16'h2005;
      mem[5] = 16'h400E;
      zflag = 1'b1;
      do_rst();
      tick(9);
      chk("br_taken", bus.pc, 16'h0004);
      zflag = 1'b0;
      do_rst();
      tick(9);
      chk("br_not", bus.pc, 16'h0006);

      // branch wrap below zero, then straight-line wrap past FFFF
      clr();
      mem[0] = 16'h2002;
      mem[2] = 16'h4008;
      zflag = 1'b1;
      do_rst();
      tick(9);
      chk("br_wrap", bus.pc, 16'hFFFB);
      tick(20);
      chk("seq_wrap", bus.pc, 16'h0000);
      chk("wrap_cnt", instr_count, 16'h0007);

      // halt at pc2
      clr();
      mem[0] = 16'h6000;
      mem[1] = 16'h6000;
      mem[2] = 16'hFFFF;
      do_rst();
      tick(11);
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_pc", bus.pc, 16'h0002);
      pulses = 0;
      tick(20);
      chk("halt_quiet", 16'(pulses), 16'd0);
      chk("halt_hold", bus.pc, 16'h0002);
      do_rst();
      chk("unhalt_pc", bus.pc, 16'h0000);
      chk("unhalt_flag", 16'(halted), 16'd0);

      // run dropped in EXEC, then reset during WB
      clr();
      mem[0] = 16'hA000;
      mem[1] = 16'h6000;
      do_rst();
      tick(3);
      run = 1'b0;
      tick();
      chk("drop_mem_we", 16'(bus.mem_we), 16'd1);
      tick(5);
      chk("drop_pulses", 16'(pulses), 16'd1);
      chk("drop_pc", bus.pc, 16'h0001);
      chk("drop_idle", 16'(busy), 16'd0);
      run = 1'b1;
      tick(4);
      chk("wb_we", 16'(bus.reg_we), 16'd1);
      rst = 1'b1;
      tick();
      chk("wbrst_we", 16'(bus.reg_we), 16'd0);
      chk("wbrst_pc", bus.pc, 16'h0000);
      rst = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
